// File: rtl/mem_access_unit_if.sv
// Memory-bus side of mem_access_unit: request/response handshake with byte enables.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic                    bus_req;
  logic                    bus_rw;
  logic [ADDR_W-OFF_W-1:0] bus_addr;
  logic [BE_W-1:0]         bus_be;
  logic [DATA_W-1:0]       bus_wr_data;
  logic [DATA_W-1:0]       bus_rd_data;
  logic                    bus_rdy;

  modport master (
    output bus_req, bus_rw, bus_addr, bus_be, bus_wr_data,
    input  bus_rd_data, bus_rdy
  );

  modport slave (
    input  bus_req, bus_rw, bus_addr, bus_be, bus_wr_data,
    output bus_rd_data, bus_rdy
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: lane steering, extension, alignment checks and a wait-state bus FSM.
// Optional bus timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_en,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_mem_wr_data,
  input  logic [ADDR_W-1:0] ex_out,
  mem_access_unit_if.master bus,
  output logic [31:0]       out,
  output logic              out_valid,
  output logic              miss_align,
  output logic              bus_err,
  output logic              stall
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("mem_access_unit: DATA_W must be 32 or 64");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    sext_q, sext_d;
  logic                    load_q, load_d;
  logic [OFF_W-1:0]        lane_q, lane_d;
  logic                    bus_req_q, bus_req_d;
  logic                    bus_rw_q, bus_rw_d;
  logic [ADDR_W-OFF_W-1:0] bus_addr_q, bus_addr_d;
  logic [BE_W-1:0]         bus_be_q, bus_be_d;
  logic [DATA_W-1:0]       bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  logic             is_mem, is_load, is_sext, misaligned, idle_mem, accept;
  logic [1:0]       size;
  logic [OFF_W-1:0] lane;
  logic [BE_W-1:0]  be_new;
  logic [DATA_W-1:0] wd_new;
  logic [DATA_W+31:0] rd_pad;
  logic [31:0]      rd_word, rd_fmt;

  always_comb begin
    is_mem  = 1'b1;
    is_load = 1'b0;
    is_sext = 1'b0;
    size    = SZ_W;
    unique case (ex_mem_op)
      4'd1: is_load = 1'b1;
      4'd2: ;
      4'd3: begin is_load = 1'b1; is_sext = 1'b1; size = SZ_H; end
      4'd4: begin is_load = 1'b1; size = SZ_H; end
      4'd5: size = SZ_H;
      4'd6: begin is_load = 1'b1; is_sext = 1'b1; size = SZ_B; end
      4'd7: begin is_load = 1'b1; size = SZ_B; end
      4'd8: size = SZ_B;
      default: is_mem = 1'b0;
    endcase
  end

  assign lane       = ex_out[OFF_W-1:0];
  assign misaligned = ((size == SZ_W) && (ex_out[1:0] != 2'b00)) ||
                      ((size == SZ_H) && ex_out[0]);
  assign idle_mem   = (state_q == IDLE) && ex_en && is_mem;
  assign accept     = idle_mem && !misaligned;
  assign miss_align = idle_mem && misaligned;

  always_comb begin
    unique case (size)
      SZ_B:    begin be_new = BE_W'(1) << lane;  wd_new = {BE_W{ex_mem_wr_data[7:0]}}; end
      SZ_H:    begin be_new = BE_W'(3) << lane;  wd_new = {(BE_W/2){ex_mem_wr_data[15:0]}}; end
      default: begin be_new = BE_W'(15) << lane; wd_new = {(DATA_W/32){ex_mem_wr_data}}; end
    endcase
  end

  // Zero padding keeps the 32-bit window in range for the top lanes of a 64-bit bus.
  assign rd_pad  = {32'd0, rd_data_q};
  assign rd_word = rd_pad[{lane_q, 3'b000} +: 32];

  always_comb begin
    unique case (size_q)
      SZ_B:    rd_fmt = {{24{sext_q & rd_word[7]}}, rd_word[7:0]};
      SZ_H:    rd_fmt = {{16{sext_q & rd_word[15]}}, rd_word[15:0]};
      default: rd_fmt = rd_word;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    sext_d        = sext_q;
    load_d        = load_q;
    lane_d        = lane_q;
    bus_req_d     = bus_req_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_data_d     = rd_data_q;
    out           = 32'd0;
    out_valid     = 1'b0;
    stall         = 1'b0;
    bus_err       = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ex_en && !is_mem) begin
          out       = ex_out[31:0];
          out_valid = 1'b1;
        end
        if (accept) begin
          stall         = 1'b1;
          state_d       = ACCESS;
          size_d        = size;
          sext_d        = is_sext;
          load_d        = is_load;
          lane_d        = lane;
          bus_req_d     = 1'b1;
          bus_rw_d      = is_load;
          bus_addr_d    = ex_out[ADDR_W-1:OFF_W];
          bus_be_d      = be_new;
          bus_wr_data_d = wd_new;
`ifdef MEM_ACCESS_TIMEOUT_EN
          cnt_d         = '0;
          err_d         = 1'b0;
`endif
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (bus.bus_rdy) begin
          rd_data_d = bus.bus_rd_data;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
        bus_err   = err_q;
        out_valid = !err_q;
        out       = (load_q && !err_q) ? rd_fmt : 32'd0;
`else
        out_valid = 1'b1;
        out       = load_q ? rd_fmt : 32'd0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      size_q        <= SZ_W;
      sext_q        <= 1'b0;
      load_q        <= 1'b0;
      lane_q        <= '0;
      bus_req_q     <= 1'b0;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wr_data_q <= '0;
      rd_data_q     <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      sext_q        <= sext_d;
      load_q        <= load_d;
      lane_q        <= lane_d;
      bus_req_q     <= bus_req_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_data_q     <= rd_data_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign bus.bus_req     = bus_req_q;
  assign bus.bus_rw      = bus_rw_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_be      = bus_be_q;
  assign bus.bus_wr_data = bus_wr_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32) with an output scoreboard; covers the timeout path when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_en = 1'b0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_mem_wr_data = 32'd0;
  logic [31:0] ex_out = 32'd0;
  logic [31:0] out;
  logic        out_valid, miss_align, bus_err, stall;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_en          (ex_en),
    .ex_mem_op      (ex_mem_op),
    .ex_mem_wr_data (ex_mem_wr_data),
    .ex_out         (ex_out),
    .bus            (bus_if),
    .out            (out),
    .out_valid      (out_valid),
    .miss_align     (miss_align),
    .bus_err        (bus_err),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid cycle must consume the oldest expected result.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("out", {32'd0, out}, {32'd0, e});
        $display("txn out=0x%08h expected=0x%08h", out, e);
      end
    end
  end

  task automatic step_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ex_en = 1'b0;
      bus_if.bus_rdy = 1'b1;
      @(negedge clk);
      chk("idle_stall", {63'd0, stall}, 64'd0);
      chk("idle_req", {63'd0, bus_if.bus_req}, 64'd0);
    end
  endtask

  task automatic pass_op(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    ex_en = 1'b1; ex_mem_op = op; ex_out = a;
    exp_q.push_back(a);
    @(negedge clk);
    chk("pass_stall", {63'd0, stall}, 64'd0);
    chk("pass_req", {63'd0, bus_if.bus_req}, 64'd0);
  endtask

  task automatic mem_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic exp_rw, input logic [3:0] exp_be, input bit chk_wd,
                        input logic [31:0] exp_wd, input logic [31:0] exp_out);
    @(posedge clk); #1;
    ex_en = 1'b1; ex_mem_op = op; ex_out = a; ex_mem_wr_data = wd;
    bus_if.bus_rdy = 1'b0;
    exp_q.push_back(exp_out);
    @(negedge clk);
    chk({nm, "_accept_stall"}, {63'd0, stall}, 64'd1);
    chk({nm, "_accept_miss"}, {63'd0, miss_align}, 64'd0);
    chk({nm, "_accept_req"}, {63'd0, bus_if.bus_req}, 64'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      ex_en = 1'b0;
      bus_if.bus_rdy = (i == waits);
      bus_if.bus_rd_data = (i == waits) ? rd : ~rd;
      @(negedge clk);
      chk({nm, "_acc_stall"}, {63'd0, stall}, 64'd1);
      chk({nm, "_acc_req"}, {63'd0, bus_if.bus_req}, 64'd1);
      chk({nm, "_acc_rw"}, {63'd0, bus_if.bus_rw}, {63'd0, exp_rw});
      chk({nm, "_acc_addr"}, {34'd0, bus_if.bus_addr}, {34'd0, a[31:2]});
      chk({nm, "_acc_be"}, {60'd0, bus_if.bus_be}, {60'd0, exp_be});
      if (chk_wd) chk({nm, "_acc_wdata"}, {32'd0, bus_if.bus_wr_data}, {32'd0, exp_wd});
    end
    // DONE: a new memory op is presented but must be ignored; bus_rdy is ignored too.
    @(posedge clk); #1;
    bus_if.bus_rdy = 1'b1; bus_if.bus_rd_data = 32'h0;
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h200;
    @(negedge clk);
    chk({nm, "_done_stall"}, {63'd0, stall}, 64'd0);
    chk({nm, "_done_req"}, {63'd0, bus_if.bus_req}, 64'd0);
    chk({nm, "_done_valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, "_done_err"}, {63'd0, bus_err}, 64'd0);
  endtask

  initial begin
    bus_if.bus_rdy = 1'b0;
    bus_if.bus_rd_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out", {32'd0, out}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_miss", {63'd0, miss_align}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_err", {63'd0, bus_err}, 64'd0);
    chk("rst_req", {63'd0, bus_if.bus_req}, 64'd0);
    chk("rst_rw", {63'd0, bus_if.bus_rw}, 64'd1);
    chk("rst_addr", {34'd0, bus_if.bus_addr}, 64'd0);
    chk("rst_be", {60'd0, bus_if.bus_be}, 64'd0);
    chk("rst_wdata", {32'd0, bus_if.bus_wr_data}, 64'd0);
    mon_en = 1'b1;

    pass_op(4'd0, 32'h0000_1234);
    pass_op(4'd12, 32'hDEAD_BEEF);
    step_idle(1);

    mem_op("ldb",  4'd6, 32'h103, 32'h0, 32'h80FF_1234, 2, 1'b1, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80);
    mem_op("ldhu", 4'd4, 32'h102, 32'h0, 32'h9ABC_0000, 1, 1'b1, 4'b1100, 1'b0, 32'h0, 32'h0000_9ABC);
    mem_op("ldh",  4'd3, 32'h102, 32'h0, 32'h9ABC_0000, 0, 1'b1, 4'b1100, 1'b0, 32'h0, 32'hFFFF_9ABC);
    mem_op("ldbu", 4'd7, 32'h101, 32'h0, 32'h0000_8000, 0, 1'b1, 4'b0010, 1'b0, 32'h0, 32'h0000_0080);
    mem_op("stb",  4'd8, 32'h001, 32'h0000_0055, 32'h0, 1, 1'b0, 4'b0010, 1'b1, 32'h5555_5555, 32'h0);
    mem_op("sth",  4'd5, 32'h102, 32'h1234_BEEF, 32'h0, 0, 1'b0, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0);
    // Back-to-back, rdy already high: 3 cycles each.
    mem_op("ldw",  4'd1, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
    mem_op("stw",  4'd2, 32'h104, 32'hA5A5_5A5A, 32'h0, 0, 1'b0, 4'b1111, 1'b1, 32'hA5A5_5A5A, 32'h0);

    // Misaligned accesses are flagged and never reach the bus.
    @(posedge clk); #1;
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h102;
    @(negedge clk);
    chk("mis_ldw_flag", {63'd0, miss_align}, 64'd1);
    chk("mis_ldw_stall", {63'd0, stall}, 64'd0);
    chk("mis_ldw_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    ex_mem_op = 4'd5; ex_out = 32'h101;
    @(negedge clk);
    chk("mis_sth_flag", {63'd0, miss_align}, 64'd1);
    chk("mis_sth_req", {63'd0, bus_if.bus_req}, 64'd0);
    @(posedge clk); #1;
    ex_mem_op = 4'd8; ex_en = 1'b0;
    @(negedge clk);
    chk("mis_off_flag", {63'd0, miss_align}, 64'd0);
    chk("mis_off_req", {63'd0, bus_if.bus_req}, 64'd0);

    // Reset while ACCESS is outstanding: request dropped, no DONE.
    @(posedge clk); #1;
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h100; bus_if.bus_rdy = 1'b0;
    @(negedge clk);
    chk("rstacc_accept_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    ex_en = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rstacc_req_before", {63'd0, bus_if.bus_req}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0; bus_if.bus_rdy = 1'b1;
    @(negedge clk);
    chk("rstacc_req_after", {63'd0, bus_if.bus_req}, 64'd0);
    chk("rstacc_stall", {63'd0, stall}, 64'd0);
    chk("rstacc_valid", {63'd0, out_valid}, 64'd0);
    step_idle(2);

`ifdef MEM_ACCESS_TIMEOUT_EN
    @(posedge clk); #1;
    ex_en = 1'b1; ex_mem_op = 4'd1; ex_out = 32'h100; bus_if.bus_rdy = 1'b0;
    @(negedge clk);
    chk("to_accept_stall", {63'd0, stall}, 64'd1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk); #1;
      ex_en = 1'b0;
      @(negedge clk);
      chk("to_req", {63'd0, bus_if.bus_req}, 64'd1);
      chk("to_stall", {63'd0, stall}, 64'd1);
      chk("to_err_early", {63'd0, bus_err}, 64'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err", {63'd0, bus_err}, 64'd1);
    chk("to_valid", {63'd0, out_valid}, 64'd0);
    chk("to_stall_rel", {63'd0, stall}, 64'd0);
    chk("to_req_drop", {63'd0, bus_if.bus_req}, 64'd0);
    chk("to_out", {32'd0, out}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err_pulse", {63'd0, bus_err}, 64'd0);
`endif

    step_idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
